pixel_readout_tx: RTL and testbench

//  Readout-side transmitter for the pixel array data buses. Samples DATA_1/DATA_2 during the

---
 rtl/pixel_readout_tx.sv | 236 +++++++++++++++++++++++
 tb/tb_pixel_readout_tx.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_tx.sv
// pixel_readout_tx: captures the last sample of each read_1/read_2 window from the
// pixel array buses, queues {channel, code} words in a small circular FIFO and
// streams each 16-bit code as an MSB byte followed by an LSB byte.
//
// Byte link handshake: a byte transfers on a rising clk edge where tx_valid and
// tx_ready are both 1. Once tx_valid is raised it stays high, and tx_data, tx_chan
// and tx_msb stay constant, until that transfer happens. tx_valid never depends
// combinationally on tx_ready.
module pixel_readout_tx #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       read_1,
    input  logic                       read_2,
    input  logic [DW-1:0]              pixdata1,
    input  logic [DW-1:0]              pixdata2,
    input  logic                       tx_ready,
    input  logic                       clr_err,
    output logic                       tx_valid,
    output logic [7:0]                 tx_data,
    output logic                       tx_chan,
    output logic                       tx_msb,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic                       proto_err,
    output logic [1:0]                 state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MSB  = 2'd1,
        S_LSB  = 2'd2
    } state_t;

    // Window tracking and hold registers
    logic          r1_q, r1_d;
    logic          r2_q, r2_d;
    logic          bad2_q, bad2_d;
    logic [DW-1:0] hold1_q, hold1_d;
    logic [DW-1:0] hold2_q, hold2_d;

    // FIFO storage: bit DW is the channel, bits DW-1:0 the pixel code
    logic [DW:0]   mem_q [DEPTH];
    logic [DW:0]   mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;

    // Serializer
    state_t        state_q, state_d;
    logic [DW-1:0] word_q, word_d;
    logic          chan_q, chan_d;

    // Sticky error flags
    logic          ovf_q, ovf_d;
    logic          perr_q, perr_d;

    // Internal strobes
    logic          fall1, fall2, both_high;
    logic          push_req, push_ok, drop_both, pop;
    logic [DW:0]   push_data;
    logic [DW:0]   pop_data;

    // Window capture: hold the latest sample, detect falling windows, pick the word to push
    always_comb begin
        fall1     = r1_q & ~read_1;
        fall2     = r2_q & ~read_2;
        both_high = read_1 & read_2;
        r1_d      = read_1;
        r2_d      = read_2;
        hold1_d   = read_1 ? pixdata1 : hold1_q;
        // read_1 wins when both buses claim the same cycle
        hold2_d   = (read_2 && !read_1) ? pixdata2 : hold2_q;
        // A channel-1 window that overlapped read_1 is poisoned until it falls
        if (fall2) begin
            bad2_d = 1'b0;
        end else if (both_high) begin
            bad2_d = 1'b1;
        end else begin
            bad2_d = bad2_q;
        end
        push_req  = 1'b0;
        push_data = '0;
        drop_both = 1'b0;
        if (fall1) begin
            push_req  = 1'b1;
            push_data = {1'b0, hold1_q};
            // Only one push per cycle: a simultaneous channel-1 fall is lost
            drop_both = fall2;
        end else if (fall2 && !bad2_q) begin
            push_req  = 1'b1;
            push_data = {1'b1, hold2_q};
        end
    end

    // Serializer next state: pop into the shift register, present MSB then LSB byte
    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        chan_d   = chan_q;
        pop      = 1'b0;
        pop_data = mem_q[rd_ptr_q];
        case (state_q)
            S_IDLE: begin
                if (level_q != '0) begin
                    pop             = 1'b1;
                    {chan_d, word_d} = pop_data;
                    state_d         = S_MSB;
                end
            end
            S_MSB: begin
                if (tx_ready) begin
                    state_d = S_LSB;
                end
            end
            S_LSB: begin
                if (tx_ready) begin
                    if (level_q != '0) begin
                        pop             = 1'b1;
                        {chan_d, word_d} = pop_data;
                        state_d         = S_MSB;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FIFO bookkeeping: a push into a full FIFO only succeeds if a pop frees a slot this cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        push_ok  = push_req && ((level_q != LW'(DEPTH)) || pop);
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + LW'(push_ok) - LW'(pop);
    end

    // Sticky flags: a new error in the same cycle as clr_err keeps the flag set
    always_comb begin
        if (drop_both || (push_req && !push_ok)) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (both_high) begin
            perr_d = 1'b1;
        end else if (clr_err) begin
            perr_d = 1'b0;
        end else begin
            perr_d = perr_q;
        end
    end

    // State registers; reset discards every queued and in-flight word
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r1_q     <= 1'b0;
            r2_q     <= 1'b0;
            bad2_q   <= 1'b0;
            hold1_q  <= '0;
            hold2_q  <= '0;
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= S_IDLE;
            word_q   <= '0;
            chan_q   <= 1'b0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            bad2_q   <= bad2_d;
            hold1_q  <= hold1_d;
            hold2_q  <= hold2_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            word_q   <= word_d;
            chan_q   <= chan_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
        end
    end

    // Byte link outputs decoded from the serializer state; all zero while idle
    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        tx_chan  = 1'b0;
        tx_msb   = 1'b0;
        case (state_q)
            S_MSB: begin
                tx_valid = 1'b1;
                tx_data  = word_q[DW-1:DW-8];
                tx_chan  = chan_q;
                tx_msb   = 1'b1;
            end
            S_LSB: begin
                tx_valid = 1'b1;
                tx_data  = word_q[7:0];
                tx_chan  = chan_q;
            end
            default: begin
                tx_valid = 1'b0;
            end
        endcase
    end

    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign proto_err  = perr_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_pixel_readout_tx.sv
// Directed bench for pixel_readout_tx: window capture, latency, back-pressure,
// FIFO overflow, protocol error and reset while a transfer is in flight.
module tb_pixel_readout_tx;

    localparam int DW    = 16;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        read_1, read_2;
    logic [15:0] pixdata1, pixdata2;
    logic        tx_ready, clr_err;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_chan, tx_msb;
    logic [2:0]  fifo_level;
    logic        overflow, proto_err;
    logic [1:0]  state_dbg;

    int n_cmp = 0;
    int n_err = 0;

    // Clock
    always #5 clk = ~clk;

    pixel_readout_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .read_1     (read_1),
        .read_2     (read_2),
        .pixdata1   (pixdata1),
        .pixdata2   (pixdata2),
        .tx_ready   (tx_ready),
        .clr_err    (clr_err),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_chan    (tx_chan),
        .tx_msb     (tx_msb),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .proto_err  (proto_err),
        .state_dbg  (state_dbg)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one window of n cycles ending with code 'last', then the falling edge
    task automatic window(input bit ch, input int n, input logic [15:0] last);
        for (int i = 0; i < n; i++) begin
            if (ch == 1'b0) begin
                read_1   = 1'b1;
                pixdata1 = (i == n - 1) ? last : (last ^ 16'h5A5A) + 16'(i);
            end else begin
                read_2   = 1'b1;
                pixdata2 = (i == n - 1) ? last : (last ^ 16'hA5A5) + 16'(i);
            end
            step();
        end
        read_1 = 1'b0;
        read_2 = 1'b0;
        step();
    endtask

    // Wait up to max_wait cycles for a valid byte, check it, let it transfer
    task automatic expect_byte(input logic [7:0] d, input bit c, input bit m,
                               input int max_wait, input string tag);
        int w = 0;
        while (tx_valid !== 1'b1 && w < max_wait) begin
            step();
            w++;
        end
        check({tag, "_valid"}, 32'(tx_valid), 32'd1);
        check({tag, "_data"},  32'(tx_data),  32'(d));
        check({tag, "_chan"},  32'(tx_chan),  32'(c));
        check({tag, "_msb"},   32'(tx_msb),   32'(m));
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        read_1   = 1'b0;
        read_2   = 1'b0;
        pixdata1 = '0;
        pixdata2 = '0;
        tx_ready = 1'b1;
        clr_err  = 1'b0;
        repeat (3) step();

        // Reset values
        check("rst_valid", 32'(tx_valid), 32'd0);
        check("rst_data",  32'(tx_data),  32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_perr",  32'(proto_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        reset = 1'b1;
        step();

        // Single 5-cycle window on channel 0, last sample h0505
        for (int k = 1; k <= 5; k++) begin
            read_1   = 1'b1;
            pixdata1 = 16'(k) * 16'h0101;
            step();
        end
        read_1 = 1'b0;
        step();
        check("t2_push_valid", 32'(tx_valid), 32'd0);
        check("t2_push_level", 32'(fifo_level), 32'd1);
        step();
        check("t2_lat_level", 32'(fifo_level), 32'd0);
        expect_byte(8'h05, 1'b0, 1'b1, 0, "t2_b0");
        expect_byte(8'h05, 1'b0, 1'b0, 0, "t2_b1");
        check("t2_end_valid", 32'(tx_valid), 32'd0);
        check("t2_end_level", 32'(fifo_level), 32'd0);

        // Two windows under back-pressure, then back-to-back drain
        tx_ready = 1'b0;
        window(1'b0, 3, 16'h1234);
        window(1'b1, 2, 16'hABCD);
        repeat (10) step();
        check("t3_hold_valid", 32'(tx_valid), 32'd1);
        check("t3_hold_data",  32'(tx_data),  32'h12);
        check("t3_hold_msb",   32'(tx_msb),   32'd1);
        check("t3_hold_chan",  32'(tx_chan),  32'd0);
        check("t3_hold_level", 32'(fifo_level), 32'd1);
        tx_ready = 1'b1;
        expect_byte(8'h12, 1'b0, 1'b1, 0, "t3_b0");
        expect_byte(8'h34, 1'b0, 1'b0, 0, "t3_b1");
        expect_byte(8'hAB, 1'b1, 1'b1, 0, "t3_b2");
        expect_byte(8'hCD, 1'b1, 1'b0, 0, "t3_b3");
        check("t3_end_valid", 32'(tx_valid), 32'd0);
        check("t3_end_level", 32'(fifo_level), 32'd0);

        // Six windows with the link stalled: one in serializer, four queued, sixth lost
        tx_ready = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            window(1'b0, 2, 16'(k) * 16'h1001);
        end
        check("t4_full_level", 32'(fifo_level), 32'd4);
        check("t4_full_ovf",   32'(overflow),   32'd1);
        check("t4_full_data",  32'(tx_data),    32'h10);
        check("t4_full_perr",  32'(proto_err),  32'd0);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("t4_clr_ovf",   32'(overflow),   32'd0);
        check("t4_clr_level", 32'(fifo_level), 32'd4);
        tx_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            expect_byte(8'(k * 16), 1'b0, 1'b1, 0, $sformatf("t4_w%0d_msb", k));
            expect_byte(8'(k),      1'b0, 1'b0, 0, $sformatf("t4_w%0d_lsb", k));
        end
        check("t4_end_valid", 32'(tx_valid), 32'd0);
        check("t4_end_level", 32'(fifo_level), 32'd0);

        // Both reads high together: protocol error, only channel 0 word survives
        read_1   = 1'b1;
        read_2   = 1'b1;
        pixdata1 = 16'h00FF;
        pixdata2 = 16'hFF00;
        repeat (3) step();
        read_1 = 1'b0;
        read_2 = 1'b0;
        step();
        check("t5_perr",  32'(proto_err),  32'd1);
        check("t5_ovf",   32'(overflow),   32'd1);
        check("t5_level", 32'(fifo_level), 32'd1);
        expect_byte(8'h00, 1'b0, 1'b1, 1, "t5_b0");
        expect_byte(8'hFF, 1'b0, 1'b0, 0, "t5_b1");
        repeat (3) step();
        check("t5_end_valid", 32'(tx_valid), 32'd0);
        check("t5_end_level", 32'(fifo_level), 32'd0);

        // Reach LSB with two words queued, then assert reset mid-cycle
        tx_ready = 1'b0;
        window(1'b0, 2, 16'hC3A5);
        window(1'b0, 2, 16'h5A3C);
        window(1'b0, 2, 16'h0F0F);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("t6_pre_msb",   32'(tx_msb),     32'd0);
        check("t6_pre_data",  32'(tx_data),    32'hA5);
        check("t6_pre_level", 32'(fifo_level), 32'd2);
        check("t6_pre_perr",  32'(proto_err),  32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("t1_async_valid", 32'(tx_valid),   32'd0);
        check("t1_async_data",  32'(tx_data),    32'd0);
        check("t1_async_level", 32'(fifo_level), 32'd0);
        check("t1_async_ovf",   32'(overflow),   32'd0);
        check("t1_async_perr",  32'(proto_err),  32'd0);
        check("t1_async_msb",   32'(tx_msb),     32'd0);
        @(negedge clk);
        reset    = 1'b1;
        tx_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("t6_quiet_valid_%0d", i), 32'(tx_valid), 32'd0);
        end
        check("t6_quiet_level", 32'(fifo_level), 32'd0);
        window(1'b0, 2, 16'h7E81);
        expect_byte(8'h7E, 1'b0, 1'b1, 1, "t6_b0");
        expect_byte(8'h81, 1'b0, 1'b0, 0, "t6_b1");
        check("t6_end_valid", 32'(tx_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
